// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state type and sizing helpers shared by the FIFO write
// arbiter and its rotate-priority finder.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Index width for n requesters; never below one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Beat counter must be able to hold max_burst itself.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority finder; returns the first set
// request at or above i_start, wrapping past N-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int i = 0; i < N; i++) begin
      w_j = IW'((int'(i_start) + i) % N);
      if (!o_found && i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-locked round-robin share of one FIFO write port.
// Define FIFO_WR_ARB_PRIO_EN to give requester 0 strict priority at arbitration.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [WIDTH-1:0]            fifo_din,
  output logic                        fifo_wr_en,
  input  logic                        fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int GW = id_w(NUM_REQ);
  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [GW-1:0] TOP_ID   = GW'(NUM_REQ - 1);

  arb_state_t    r_state;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant;
  logic [CW-1:0] r_beat_cnt;

  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_sel;
  logic          w_upd_ptr;
  logic          w_g_valid;
  logic          w_g_last;
  logic          w_accept;
  logic          w_end;
  logic [GW-1:0] w_next_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_pick (
    .i_req   (req_valid),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef FIFO_WR_ARB_PRIO_EN
  assign w_sel     = req_valid[0] ? '0 : w_pick;
  assign w_upd_ptr = (r_grant != '0);
`else
  assign w_sel     = w_pick;
  assign w_upd_ptr = 1'b1;
`endif

  assign w_g_valid  = req_valid[r_grant];
  assign w_g_last   = req_last[r_grant];
  // srst suppresses the write of a burst it abandons
  assign w_accept   = (r_state == BURST) && w_g_valid
                    && !fifo_full && !srst;
  assign w_end      = w_accept
                    && (w_g_last || (r_beat_cnt == LAST_CNT));
  assign w_next_ptr = (r_grant == TOP_ID) ? '0 : r_grant + GW'(1);

  assign fifo_wr_en = w_accept;
  assign fifo_din   = (r_state == BURST)
                    ? req_data[int'(r_grant)*WIDTH +: WIDTH]
                    : '0;
  assign grant_id   = r_grant;
  assign busy       = (r_state == BURST);

  always_comb begin
    req_ready = '0;
    if ((r_state == BURST) && !srst)
      req_ready[r_grant] = !fifo_full;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant    <= w_sel;
            r_beat_cnt <= '0;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
            if (w_end) begin
              r_state <= IDLE;
              if (w_upd_ptr)
                r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios against a MAX_BURST=16 instance
// and a MAX_BURST=4 instance sharing the same producer stimulus.
module tb_fifo_wr_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk       = 1'b0;
  logic           srst      = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic           fifo_full = 1'b0;

  logic [N-1:0] rdy16, rdy4;
  logic [W-1:0] din16, din4;
  logic         wr16, wr4;
  logic [1:0]   gid16, gid4;
  logic         busy16, busy4;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(16)) dut (
    .clk        (clk),
    .srst       (srst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (rdy16),
    .fifo_din   (din16),
    .fifo_wr_en (wr16),
    .fifo_full  (fifo_full),
    .grant_id   (gid16),
    .busy       (busy16)
  );

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut4 (
    .clk        (clk),
    .srst       (srst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (rdy4),
    .fifo_din   (din4),
    .fifo_wr_en (wr4),
    .fifo_full  (fifo_full),
    .grant_id   (gid4),
    .busy       (busy4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit sel4   = 1'b0;

  logic [W:0]   q[N][$];
  logic [W-1:0] wlog_d[$];
  logic [1:0]   wlog_g[$];
  int           wlog_c[$];

  logic         s_wr, s_busy;
  logic [N-1:0] s_rdy;
  logic [W-1:0] s_din;
  logic [1:0]   s_gid;

  function automatic logic [W-1:0] mk(input int i, input int k);
    return (W'(i) << 24) | W'(k);
  endfunction

  task automatic push(input int i, input int k, input bit last);
    q[i].push_back({last, mk(i, k)});
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = q[i][0][W-1:0];
        req_last[i]        = q[i][0][W];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    cyc++;
    s_wr   = sel4 ? wr4   : wr16;
    s_rdy  = sel4 ? rdy4  : rdy16;
    s_din  = sel4 ? din4  : din16;
    s_gid  = sel4 ? gid4  : gid16;
    s_busy = sel4 ? busy4 : busy16;
    acc = req_valid & s_rdy;
    if (s_wr) begin
      wlog_d.push_back(s_din);
      wlog_g.push_back(s_gid);
      wlog_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    apply();
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (wlog_d.size() < n && b < budget) begin
      step();
      b++;
    end
    ok = (wlog_d.size() >= n);
  endtask

  task automatic pulse_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    apply();
    srst = 1'b1;
    step();
    srst = 1'b0;
    wlog_d.delete();
    wlog_g.delete();
    wlog_c.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 0, 1'b0);
      push(i, 1, 1'b1);
    end
    push(0, 2, 1'b0);
    push(0, 3, 1'b1);
    apply();
    srst = 1'b1;
    repeat (2) begin
      step();
      checks++;
      if (s_wr !== 1'b0) begin
        errors++; $display("FAIL rst_wr_en got %b want 0", s_wr);
      end
      checks++;
      if (s_rdy !== 4'b0000) begin
        errors++; $display("FAIL rst_ready got %b want 0000", s_rdy);
      end
      checks++;
      if (s_din !== 32'h0) begin
        errors++; $display("FAIL rst_din got %h want 0", s_din);
      end
      checks++;
      if (s_busy !== 1'b0) begin
        errors++; $display("FAIL rst_busy got %b want 0", s_busy);
      end
      checks++;
      if (s_gid !== 2'd0) begin
        errors++; $display("FAIL rst_grant got %0d want 0", s_gid);
      end
    end
    srst = 1'b0;
  endtask

  task automatic test_round_robin();
    int crel;
    bit ok;
    int eg[10];
    int ek[10];
    eg = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    ek = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
    crel = cyc;
    wait_writes(10, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_timeout got %0d writes want 10", wlog_d.size());
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (wlog_d[k] !== mk(eg[k], ek[k])) begin
        errors++;
        $display("FAIL rr_data[%0d] got %h want %h", k, wlog_d[k], mk(eg[k], ek[k]));
      end
      checks++;
      if (wlog_g[k] !== 2'(eg[k])) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %0d want %0d", k, wlog_g[k], eg[k]);
      end
      checks++;
      if (wlog_c[k] != crel + 2 + k + k / 2) begin
        errors++;
        $display("FAIL rr_cycle[%0d] got %0d want %0d", k, wlog_c[k], crel + 2 + k + k / 2);
      end
    end
  endtask

  task automatic test_max_burst();
    bit ok;
    int eg[12];
    int ek[12];
    eg = '{2, 2, 2, 2, 3, 3, 2, 2, 2, 2, 2, 2};
    ek = '{0, 1, 2, 3, 0, 1, 4, 5, 6, 7, 8, 9};
    sel4 = 1'b1;
    pulse_reset();
    for (int k = 0; k < 10; k++) push(2, k, 1'b0);
    push(3, 0, 1'b0);
    push(3, 1, 1'b1);
    apply();
    wait_writes(12, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cap_timeout got %0d writes want 12", wlog_d.size());
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (wlog_d[k] !== mk(eg[k], ek[k]) || wlog_g[k] !== 2'(eg[k])) begin
        errors++;
        $display("FAIL cap_beat[%0d] got %h/g%0d want %h/g%0d",
                 k, wlog_d[k], wlog_g[k], mk(eg[k], ek[k]), eg[k]);
      end
    end
    repeat (2) step();
    checks++;
    if (s_busy !== 1'b1 || s_gid !== 2'd2 || s_wr !== 1'b0) begin
      errors++;
      $display("FAIL cap_hold got busy%b g%0d wr%b want busy1 g2 wr0", s_busy, s_gid, s_wr);
    end
    checks++;
    if (wlog_d.size() != 12) begin
      errors++; $display("FAIL cap_count got %0d want 12", wlog_d.size());
    end
    sel4 = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    pulse_reset();
    for (int k = 0; k < 6; k++) push(1, k, k == 5);
    apply();
    wait_writes(2, 10, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_start got %0d writes want 2", wlog_d.size());
    end
    fifo_full = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (s_wr !== 1'b0 || s_rdy !== 4'b0000 || s_busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_full got wr%b rdy%b busy%b want wr0 rdy0000 busy1", s_wr, s_rdy, s_busy);
      end
    end
    checks++;
    if (wlog_d.size() != 2) begin
      errors++; $display("FAIL bp_stall_count got %0d want 2", wlog_d.size());
    end
    fifo_full = 1'b0;
    step();
    checks++;
    if (s_wr !== 1'b1 || s_rdy !== 4'b0010) begin
      errors++; $display("FAIL bp_resume got wr%b rdy%b want wr1 rdy0010", s_wr, s_rdy);
    end
    wait_writes(6, 20, ok);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (wlog_d[k] !== mk(1, k)) begin
        errors++; $display("FAIL bp_data[%0d] got %h want %h", k, wlog_d[k], mk(1, k));
      end
    end
    repeat (3) step();
    checks++;
    if (wlog_d.size() != 6 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end got %0d writes busy%b want 6 busy0", wlog_d.size(), s_busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_reset();
    push(2, 0, 1'b1);
    apply();
    wait_writes(1, 10, ok);
    for (int k = 0; k < 5; k++) push(1, k, k == 4);
    apply();
    wait_writes(3, 20, ok);
    checks++;
    if (wlog_d[1] !== mk(1, 0) || wlog_d[2] !== mk(1, 1) || wlog_g[2] !== 2'd1) begin
      errors++;
      $display("FAIL rm_pre got %h %h g%0d want %h %h g1",
               wlog_d[1], wlog_d[2], wlog_g[2], mk(1, 0), mk(1, 1));
    end
    push(3, 0, 1'b0);
    push(3, 1, 1'b1);
    apply();
    srst = 1'b1;
    step();
    checks++;
    if (s_wr !== 1'b0 || s_rdy !== 4'b0000) begin
      errors++; $display("FAIL rm_srst_cycle got wr%b rdy%b want wr0 rdy0000", s_wr, s_rdy);
    end
    checks++;
    if (wlog_d.size() != 3) begin
      errors++; $display("FAIL rm_srst_count got %0d want 3", wlog_d.size());
    end
    srst = 1'b0;
    step();
    checks++;
    if (s_busy !== 1'b0 || s_wr !== 1'b0) begin
      errors++; $display("FAIL rm_idle got busy%b wr%b want busy0 wr0", s_busy, s_wr);
    end
    wait_writes(4, 10, ok);
    checks++;
    if (wlog_d[3] !== mk(1, 2) || wlog_g[3] !== 2'd1) begin
      errors++;
      $display("FAIL rm_regrant got %h g%0d want %h g1", wlog_d[3], wlog_g[3], mk(1, 2));
    end
  endtask

  task automatic test_prio();
    bit ok;
    int eg[6];
    int ek[6];
`ifdef FIFO_WR_ARB_PRIO_EN
    eg = '{0, 0, 0, 2, 2, 2};
    ek = '{1, 2, 3, 0, 1, 2};
`else
    eg = '{2, 0, 2, 0, 2, 0};
    ek = '{0, 1, 1, 2, 2, 3};
`endif
    pulse_reset();
    push(0, 0, 1'b1);
    apply();
    wait_writes(1, 10, ok);
    for (int k = 1; k < 4; k++) push(0, k, 1'b1);
    for (int k = 0; k < 3; k++) push(2, k, 1'b1);
    apply();
    wait_writes(7, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL prio_timeout got %0d writes want 7", wlog_d.size());
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (wlog_d[k+1] !== mk(eg[k], ek[k]) || wlog_g[k+1] !== 2'(eg[k])) begin
        errors++;
        $display("FAIL prio_beat[%0d] got %h/g%0d want %h/g%0d",
                 k, wlog_d[k+1], wlog_g[k+1], mk(eg[k], ek[k]), eg[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_burst();
    test_backpressure();
    test_reset_mid();
    test_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
